spi_mem_responder: RTL and testbench
====================================

SPI_MEM_RESPONDER -- requirements
Module: spi_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 32, number of 8-bit memory words; valid addresses are 0..MEM_DEPTH-1.
REQ-002 SHALL have parameter READ_LAT, default 0, extra idle cycles between end of address phase and o_ready.
REQ-003 SHALL have port clk  input  1  rising-edge clock; all logic sits in this single domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_cs  input  1  chip select, active-low, driven by the SPI master.
REQ-006 SHALL have port i_mosi  input  1  serial command/data from the master, LSB first.
REQ-007 SHALL have port o_miso  output  1  serial read data to the master, LSB first.
REQ-008 SHALL have port o_ready  output  1  one-cycle pulse; read data is presented on o_miso.
REQ-009 SHALL have port o_op_done  output  1  one-cycle pulse; write committed to memory.

Function
REQ-010 SHALL hold a MEM_DEPTH x 8 register array, written only by a completed write frame.
REQ-011 SHALL use states IDLE, START, CMD, WDATA, COMMIT, RWAIT, RSEND.
REQ-012 IDLE: at edge S, the first edge with i_cs sampled 0, SHALL go to START; i_mosi at S is ignored (lead-in).
REQ-013 SHALL sample frame bit k (k=0..16) from i_mosi at edge S+1+k: bit0 = op (1 write, 0 read), bits1-8 = addr[7:0], bits9-16 = data[7:0].
REQ-014 CMD collects bits 0-8 (edges S+1..S+9); at S+9 SHALL go to WDATA if op=1, else RWAIT.
REQ-015 WDATA collects bits 9-16 (edges S+10..S+17), then SHALL go to COMMIT.
REQ-016 COMMIT, edge S+18: SHALL write mem[addr]=data if addr<MEM_DEPTH, pulse o_op_done high for exactly one cycle, then go to IDLE.
REQ-017 addr>=MEM_DEPTH on write: no memory change, o_op_done still pulsed (master must not hang).
REQ-018 RWAIT SHALL wait READ_LAT cycles; at edge R=S+10+READ_LAT it SHALL set o_ready=1 and o_miso=rd[0], then go to RSEND.
REQ-019 rd = mem[addr] latched at R; rd = 8'h00 if addr>=MEM_DEPTH.
REQ-020 o_ready SHALL return to 0 at R+1; o_miso SHALL hold rd[0] through R+1 and take rd[i-1] at edge R+i for i=2..8.
REQ-021 At R+9 SHALL set o_miso=0 and go to IDLE; the master samples rd[i] at edge R+2+i.
REQ-022 i_cs sampled 1 at any edge in S+1..S+9, or in S+10..S+17 for a write, SHALL abort: go to IDLE with no memory write and no pulse.
REQ-023 i_cs SHALL be ignored in COMMIT, RWAIT and RSEND (the master raises cs after the address phase).
REQ-024 i_cs low while not in IDLE SHALL NOT start a new frame; a frame starts only from IDLE.
REQ-025 o_miso SHALL be 0 whenever not in RWAIT/RSEND, except as driven at R per REQ-018.
REQ-026 o_ready and o_op_done SHALL never be high in the same cycle.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, o_miso=0, o_ready=0, o_op_done=0, bit counter=0 and shift registers=0.
REQ-028 rst SHALL clear every memory word to 8'h00.
REQ-029 rst mid-frame SHALL discard the frame (no write, no pulse); the first frame after rst is decoded normally.

Verification
REQ-030 Write: frame op=1, addr=3, data=0xA5 -> mem[3]=0xA5 at S+18, o_op_done high for exactly edge S+18..S+19.
REQ-031 Read back: frame op=0, addr=3, READ_LAT=0 -> o_ready pulse at S+10; o_miso sequence 1,0,1,0,0,1,0,1; master captures 0xA5.
REQ-032 After reset, read addr 31 -> 0x00; write addr 40 data 0xFF -> o_op_done pulses, memory unchanged, read addr 40 -> 0x00.
REQ-033 Abort: write frame to addr 5, i_cs raised before S+8 -> no o_op_done, mem[5] unchanged; next full write to addr 5 = 0x3C succeeds.
REQ-034 rst asserted at R+4 during a read -> next cycle o_miso=0, o_ready=0, state IDLE, all memory reads back 0x00.
REQ-035 Back-to-back with spi_master: write 0x5A@7, read @7, write 0x11@0, read @0 -> master o_dout 0x5A then 0x11, o_err=0.

Source files
------------

// File: rtl/spi_mem_responder.sv
// SPI-style memory responder: LSB-first frames carrying op, address and
// write data, backed by a resettable MEM_DEPTH x 8 register array.
module spi_mem_responder #(
  parameter int MEM_DEPTH = 32,
  parameter int READ_LAT  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_ready,
  output logic o_op_done
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    WDATA,
    COMMIT,
    RWAIT,
    RSEND
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  rd_q, rd_d;
  logic        miso_q, miso_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [7:0]  mem_q [MEM_DEPTH];
  logic [7:0]  mem_d [MEM_DEPTH];

  logic        addr_ok;
  logic [7:0]  mem_rd;
  logic [2:0]  bit_idx;

  // Address decode and bit select for the serial read-out.
  always_comb begin
    addr_ok = 32'(addr_q) < MEM_DEPTH;
    mem_rd  = 8'h00;
    if (addr_ok) begin
      mem_rd = mem_q[addr_q[AW-1:0]];
    end
    // cnt 1..8 selects rd bit 0..7; 8 wraps to index 7.
    bit_idx = cnt_q[2:0] - 3'd1;
  end

  // Frame FSM: next state, shift registers, memory update and outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    miso_d  = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    mem_d   = mem_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (!i_cs) begin
          state_d = START;
        end
      end

      START: begin
        if (i_cs) begin
          state_d = IDLE;
        end else begin
          op_d    = i_mosi;
          cnt_d   = 8'd0;
          state_d = CMD;
        end
      end

      CMD: begin
        if (i_cs) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          addr_d = {i_mosi, addr_q[7:1]};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d   = 8'd0;
            state_d = op_q ? WDATA : RWAIT;
          end
        end
      end

      WDATA: begin
        if (i_cs) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          data_d = {i_mosi, data_q[7:1]};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d   = 8'd0;
            state_d = COMMIT;
          end
        end
      end

      COMMIT: begin
        // Out-of-range writes still complete so the master never stalls.
        if (addr_ok) begin
          mem_d[addr_q[AW-1:0]] = data_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      RWAIT: begin
        if (32'(cnt_q) >= READ_LAT) begin
          rd_d    = mem_rd;
          miso_d  = mem_rd[0];
          ready_d = 1'b1;
          cnt_d   = 8'd1;
          state_d = RSEND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RSEND: begin
        if (cnt_q == 8'd9) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          miso_d = rd_q[bit_idx];
          cnt_d  = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      op_q    <= 1'b0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      rd_q    <= 8'd0;
      miso_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      miso_q  <= miso_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Memory array, cleared on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (rst) begin
        mem_q[i] <= 8'h00;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign o_miso    = miso_q;
  assign o_ready   = ready_q;
  assign o_op_done = done_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: a bit-level master model drives
// frames and checks pulses, serial read data and reset behaviour.
module tb_spi_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_cs = 1'b1;
  logic i_mosi = 1'b0;
  logic o_miso, o_ready, o_op_done;

  int checks = 0;
  int errors = 0;

  spi_mem_responder #(.MEM_DEPTH(32), .READ_LAT(0)) dut (
    .clk(clk),
    .rst(rst),
    .i_cs(i_cs),
    .i_mosi(i_mosi),
    .o_miso(o_miso),
    .o_ready(o_ready),
    .o_op_done(o_op_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Write frame; abort_at >= 0 raises cs in place of frame bit abort_at.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          input int abort_at);
    logic [16:0] fb;
    logic        seen;
    fb = {d, a, 1'b1};
    i_cs = 1'b0;
    i_mosi = 1'b0;
    tick();
    for (int k = 0; k < 17; k++) begin
      if (k == abort_at) begin
        i_cs = 1'b1;
        break;
      end
      i_mosi = fb[k];
      tick();
    end
    if (abort_at >= 0) begin
      seen = 1'b0;
      for (int c = 0; c < 24; c++) begin
        tick();
        seen = seen | o_op_done;
      end
      chk1("abort_no_done", seen, 1'b0);
    end else begin
      chk1("done_pre", o_op_done, 1'b0);
      i_cs = 1'b1;
      i_mosi = 1'b0;
      tick();
      chk1("done_pulse", o_op_done, 1'b1);
      chk1("ready_not_done", o_ready, 1'b0);
      tick();
      chk1("done_clear", o_op_done, 1'b0);
    end
    i_cs = 1'b1;
    i_mosi = 1'b0;
    tick();
  endtask

  // Read frame; rst_at >= 0 asserts reset at edge R+rst_at.
  task automatic do_read(input logic [7:0] a, input logic [7:0] exp,
                         input string tag, input int rst_at);
    logic [8:0] fb;
    logic [7:0] cap;
    fb = {a, 1'b0};
    cap = 8'h00;
    i_cs = 1'b0;
    i_mosi = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) begin
      i_mosi = fb[k];
      tick();
    end
    i_cs = 1'b1;
    i_mosi = 1'b0;
    tick();
    if (rst_at < 0) begin
      chk1({tag, "_ready"}, o_ready, 1'b1);
      chk1({tag, "_nodone"}, o_op_done, 1'b0);
      chk1({tag, "_bit0_at_r"}, o_miso, exp[0]);
      for (int i = 0; i < 8; i++) begin
        tick();
        cap[i] = o_miso;
        if (i == 0) begin
          chk1({tag, "_ready_low"}, o_ready, 1'b0);
        end
      end
      chk({tag, "_data"}, cap, exp);
      tick();
      chk1({tag, "_miso_idle"}, o_miso, 1'b0);
    end else begin
      for (int i = 0; i < rst_at - 1; i++) begin
        tick();
      end
      rst = 1'b1;
      tick();
      chk1("rst_mid_miso", o_miso, 1'b0);
      chk1("rst_mid_ready", o_ready, 1'b0);
      chk1("rst_mid_done", o_op_done, 1'b0);
      rst = 1'b0;
    end
    tick();
  endtask

  initial begin
    logic [7:0] zero;
    zero = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    chk1("reset_miso", o_miso, 1'b0);
    chk1("reset_ready", o_ready, 1'b0);
    chk1("reset_done", o_op_done, 1'b0);
    rst = 1'b0;
    tick();

    do_read(8'd31, 8'h00, "rd31_after_reset", -1);
    do_write(8'd3, 8'hA5, -1);
    do_read(8'd3, 8'hA5, "rd3", -1);

    do_write(8'd40, 8'hFF, -1);
    do_read(8'd40, 8'h00, "rd40", -1);
    do_read(8'd8, 8'h00, "rd8_alias", -1);
    do_read(8'd3, 8'hA5, "rd3_kept", -1);

    do_write(8'd5, 8'h77, 6);
    do_read(8'd5, 8'h00, "rd5_aborted", -1);
    do_write(8'd5, 8'h77, 12);
    do_read(8'd5, 8'h00, "rd5_abort_data", -1);
    do_write(8'd5, 8'h3C, -1);
    do_read(8'd5, 8'h3C, "rd5", -1);

    do_write(8'd7, 8'h5A, -1);
    do_read(8'd7, 8'h5A, "rd7", -1);
    do_write(8'd0, 8'h11, -1);
    do_read(8'd0, 8'h11, "rd0", -1);
    do_read(8'd5, 8'h3C, "rd5_still", -1);

    do_read(8'd0, 8'h11, "rd0_rst", 4);
    for (int a = 0; a < 32; a++) begin
      do_read(8'(a), zero, "rd_cleared", -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
